// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the instruction-fetch stage.
//   fetch_state_e : fetch FSM states (FETCH, DROP, BUF)
//   PC_STEP       : byte distance between sequential instructions
//   INSTR_ZERO    : value driven on instr/PCplus4 when nothing is delivered
//   pc_next()     : sequential successor of a PC (32-bit modulo)
//   word_align()  : clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DROP  = 2'd1,
        BUF   = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_STEP    = 32'd4;
    localparam logic [31:0] INSTR_ZERO = 32'h0000_0000;

    // Sequential PC; the add is 32 bits wide so 32'hFFFF_FFFC wraps to 0.
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// -----------------------------------------------------------------------------
// fetch_skid_buf
// One-entry holding register for a fetch response that arrived while the
// pipeline was stalled. Only exists when FETCH_BUF_EN is defined.
//   clk      in   clock
//   rst      in   asynchronous active-high reset
//   load_i   in   capture data_i/pc4_i and mark valid
//   clear_i  in   invalidate the entry (load_i wins if both are set)
//   data_i   in   32-bit instruction word
//   pc4_i    in   32-bit PC+4 of that word
//   valid_o  out  entry holds a word
//   data_o   out  stored word
//   pc4_o    out  stored PC+4
// -----------------------------------------------------------------------------
`ifdef FETCH_BUF_EN
module fetch_skid_buf
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] data_i,
    input  logic [31:0] pc4_i,
    output logic        valid_o,
    output logic [31:0] data_o,
    output logic [31:0] pc4_o
);

    logic        valid_q;
    logic [31:0] data_q;
    logic [31:0] pc4_q;

    // Buffer entry storage: load has priority over clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= INSTR_ZERO;
            pc4_q   <= INSTR_ZERO;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            pc4_q   <= pc4_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_q;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign pc4_o   = pc4_q;

endmodule
`endif

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage in front of the IF/ID register. Owns the PC, runs a
// single-outstanding req/ack fetch to instruction memory, and tells IF/ID when
// to capture (hold=0) or invalidate (IF_flush=1). Redirects from ID either
// retarget immediately (when the in-flight fetch completes in the same cycle)
// or park the target in tgt and wait in DROP for the wrong-path ack.
//
// Configuration macro: FETCH_BUF_EN
//   undefined : a response arriving under stall is dropped and refetched.
//   defined   : the response is parked in fetch_skid_buf (state BUF) and
//               delivered in the first cycle without stall.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   stall        in   hazard stall, IF/ID keeps its contents
//   redirect     in   one-cycle redirect pulse from ID
//   redirect_pc  in   redirect target (32)
//   imem_req     out  fetch request
//   imem_addr    out  fetch address (32), word aligned
//   imem_ack     in   response valid, imem_rdata valid this cycle
//   imem_rdata   in   fetched word (32)
//   instr        out  instruction to IF/ID (32), zero while hold=1
//   PCplus4      out  fetch address + 4 to IF/ID (32), zero while hold=1
//   hold         out  IF/ID must not capture
//   IF_flush     out  IF/ID must invalidate (implies hold=1)
// -----------------------------------------------------------------------------
module if_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] PCplus4,
    output logic        hold,
    output logic        IF_flush
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  tgt_q, tgt_d;

    logic         req_s;
    logic         deliver_s;
    logic [31:0]  instr_s;
    logic [31:0]  pc4_s;
    logic [31:0]  redirect_tgt_s;

    assign redirect_tgt_s = word_align(redirect_pc);

`ifdef FETCH_BUF_EN
    logic         buf_load_s;
    logic         buf_clear_s;
    logic         buf_valid_s;
    logic [31:0]  buf_data_s;
    logic [31:0]  buf_pc4_s;

    fetch_skid_buf u_skid_buf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (buf_load_s),
        .clear_i (buf_clear_s),
        .data_i  (imem_rdata),
        .pc4_i   (pc_next(pc_q)),
        .valid_o (buf_valid_s),
        .data_o  (buf_data_s),
        .pc4_o   (buf_pc4_s)
    );
`endif

    // State, PC and pending-redirect target registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            tgt_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
        end
    end

    // Next-state logic and unmasked delivery outputs.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        tgt_d     = tgt_q;
        req_s     = 1'b0;
        deliver_s = 1'b0;
        instr_s   = INSTR_ZERO;
        pc4_s     = INSTR_ZERO;
`ifdef FETCH_BUF_EN
        buf_load_s  = 1'b0;
        buf_clear_s = 1'b0;
`endif
        case (state_q)
            FETCH: begin
                req_s = 1'b1;
                if (redirect) begin
                    // Ack in the same cycle closes the wrong-path fetch, so
                    // the target can be requested immediately.
                    if (imem_ack) begin
                        pc_d = redirect_tgt_s;
                    end else begin
                        tgt_d   = redirect_tgt_s;
                        state_d = DROP;
                    end
                end else if (stall) begin
                    if (imem_ack) begin
`ifdef FETCH_BUF_EN
                        buf_load_s = 1'b1;
                        pc_d       = pc_next(pc_q);
                        state_d    = BUF;
`else
                        // Data discarded; pc unchanged so the word is refetched.
                        pc_d = pc_q;
`endif
                    end else begin
                        pc_d = pc_q;
                    end
                end else if (imem_ack) begin
                    deliver_s = 1'b1;
                    instr_s   = imem_rdata;
                    pc4_s     = pc_next(pc_q);
                    pc_d      = pc_next(pc_q);
                end else begin
                    pc_d = pc_q;
                end
            end
            DROP: begin
                // Wrong-path request stays on the bus until memory answers it.
                req_s = 1'b1;
                if (redirect) begin
                    tgt_d = redirect_tgt_s;
                end else begin
                    tgt_d = tgt_q;
                end
                if (imem_ack) begin
                    pc_d    = redirect ? redirect_tgt_s : tgt_q;
                    state_d = FETCH;
                end else begin
                    state_d = DROP;
                end
            end
`ifdef FETCH_BUF_EN
            BUF: begin
                req_s = 1'b0;
                if (redirect) begin
                    buf_clear_s = 1'b1;
                    pc_d        = redirect_tgt_s;
                    state_d     = FETCH;
                end else if (!stall && buf_valid_s) begin
                    deliver_s   = 1'b1;
                    instr_s     = buf_data_s;
                    pc4_s       = buf_pc4_s;
                    buf_clear_s = 1'b1;
                    state_d     = FETCH;
                end else begin
                    state_d = BUF;
                end
            end
`endif
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Reset overrides everything, so outputs are masked by rst directly
    // rather than waiting for the state registers.
    assign imem_req  = req_s & ~rst;
    assign imem_addr = pc_q;
    assign IF_flush  = redirect & ~rst;
    assign hold      = ~(deliver_s & ~rst);
    assign instr     = (deliver_s & ~rst) ? instr_s : INSTR_ZERO;
    assign PCplus4   = (deliver_s & ~rst) ? pc4_s   : INSTR_ZERO;

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage driving the IF/ID pipeline register: owns the PC, issues requests to instruction memory over a req/ack handshake, and presents `instr`/`PCplus4` together with the `hold` and `IF_flush` controls the IF/ID register consumes. Absorbs variable memory latency, hazard stalls, and branch/jump redirects resolved in ID, including discarding in-flight fetches on the wrong path.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hazard-unit stall; IF/ID must keep its contents.
- `redirect`  in  1  single-cycle pulse; branch taken or jump resolved in ID.
- `redirect_pc`  in  32  target PC; valid when `redirect`=1.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; word-aligned.
- `imem_ack`  in  1  response valid; `imem_rdata` valid in the same cycle.
- `imem_rdata`  in  32  fetched instruction.
- `instr`  out  32  instruction to IF/ID.
- `PCplus4`  out  32  fetch address + 4 to IF/ID.
- `hold`  out  1  1 = IF/ID must not capture.
- `IF_flush`  out  1  1 = IF/ID must invalidate; always asserted together with `hold`=1.

## Operation
- Registers: `pc`, `state`, `tgt` (pending redirect target).
- States: FETCH, DROP, plus BUF when `FETCH_BUF_EN` is defined.
- Handshake: while `imem_req`=1, `imem_addr` is stable until the `imem_ack` cycle. Exactly one request is outstanding at a time. `imem_ack` with `imem_req`=0 is ignored.
- FETCH: `imem_req`=1, `imem_addr`=`pc`.
  - ack & ~stall & ~redirect: deliver (`instr`=`imem_rdata`, `PCplus4`=`pc`+4, `hold`=0); `pc`<=`pc`+4.
  - ack & stall & ~redirect: without the macro, discard the data and keep `pc`, so the next cycle re-requests the same address. With the macro, capture the data in the buffer, advance `pc`<=`pc`+4, and go to BUF.
  - redirect & ack: discard the data; `pc`<=`redirect_pc`; stay in FETCH.
  - redirect & ~ack: `tgt`<=`redirect_pc`; go to DROP.
- DROP: keep `imem_req`/`imem_addr` unchanged. On ack, discard the data, set `pc`<=`tgt`, and go to FETCH. A new redirect in DROP overwrites `tgt` (latest wins).
- BUF: `imem_req`=0.
  - ~stall & ~redirect: deliver the buffered word and its PC+4, then go to FETCH.
  - redirect: drop the buffer; `pc`<=`redirect_pc`; go to FETCH.
- Priority: rst > redirect > stall > ack.
- `hold` = ~deliver. `IF_flush` = `redirect` (combinational, one cycle per pulse), which forces `hold`=1.
- `instr` and `PCplus4` are 0 whenever `hold`=1.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `hold`=1, `IF_flush`=0, `instr`=0, `PCplus4`=0. State is FETCH and `pc`=`RESET_PC`.
- First request is issued in the first cycle after `rst` deasserts.
- Zero-wait memory (ack in the request cycle) sustains 1 instruction/cycle with `imem_req` held at 1.
- An ack in cycle N with no stall is captured by IF/ID at the end of cycle N. The next address is on `imem_addr` in cycle N+1.
- Redirect in cycle N: `IF_flush`=1 in cycle N. The first request to the target is in cycle N+1, or in the cycle after the pending ack when in DROP.
- Reset mid-request: the outstanding request is abandoned and a late ack after reset is ignored. The memory side is reset with the same `rst`.

## Configuration
- `FETCH_BUF_EN` defined: a one-entry buffer (word + PC+4) holds a response that arrives during `stall`. No refetch is needed; the BUF state exists.
- `FETCH_BUF_EN` undefined: a response that arrives during `stall` is dropped and the same address is refetched. There is no BUF state and no buffer storage.

## Structure
- Shared package `mips_pkg`: state enum (FETCH, DROP, BUF), `PC_STEP`=4, `INSTR_ZERO`=32'h0.
- Sub-module `fetch_skid_buf`: one-entry buffer with load/clear/valid. It is instantiated only under `FETCH_BUF_EN`.

## Test plan
- Reset release, zero-wait memory -> addresses 0x0, 0x4, 0x8 on consecutive cycles; `hold`=0 each cycle; `PCplus4`=0x4, 0x8, 0xC.
- 3-cycle ack latency at 0x10 -> `imem_addr` stays 0x10 for 3 cycles with `hold`=1, then one delivery with `PCplus4`=0x14.
- `stall` during the ack of 0x20 -> without macro: `hold`=1 and 0x20 is refetched after `stall` drops. With macro: no refetch, and 0x20 data is delivered in the first non-stall cycle.
- `redirect` to 0x100 while 0x40 is outstanding (ack 2 cycles later) -> `IF_flush`=1 for one cycle, 0x40 data is never delivered, and the next request is 0x100.
- `redirect` to 0x200 coincident with the ack of 0x50 -> 0x50 is discarded, `hold`=1, and `imem_addr`=0x200 next cycle. Redirect with `stall`=1 also flushes.
- `rst` pulse during an outstanding request -> all outputs take their reset values immediately, and fetch restarts at `RESET_PC`.
